prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction memory. The core only reads instruction memory; this block fills it at run time.
- Receives a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instruction words.
- Writes each word sequentially into the instruction memory write port, starting at word address 0.
- Holds the processor (cpu_hold) while loading and checks a trailing XOR checksum byte.

Parameters:
- DATA_W, 16: instruction word width; must equal the instruction memory column width.
- ADDR_W, 4: instruction memory word-address width, matching pc[4:1].
- DEPTH, 16: number of instruction memory words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load request; sampled only in IDLE.
- word_count  in  ADDR_W+1  number of words to load; sampled on accepted start.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_waddr  out  ADDR_W  word address.
- imem_wdata  out  DATA_W  instruction word.
- cpu_hold  out  1  processor PC/register writes frozen.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared on next accepted start.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; rx_ready, imem_we, cpu_hold, busy, done, err = 0; imem_waddr=0; imem_wdata=0; byte/word counters=0; checksum=0.
- Byte transfer: occurs only on a cycle with rx_valid && rx_ready. rx_data is ignored otherwise.
- IDLE:
  - start=1 with 1 <= word_count <= DEPTH -> HI. Latch word_count, clear err, checksum=0, waddr=0, cpu_hold=1, busy=1.
  - start=1 with word_count=0 or > DEPTH -> ERR_DONE. No writes, no cpu_hold, err=1.
- HI: rx_ready=1. On transfer, latch byte as wdata[15:8], checksum ^= byte -> LO.
- LO: rx_ready=1. On transfer, latch byte as wdata[7:0], checksum ^= byte -> WRITE.
- WRITE:
  - rx_ready=0; imem_we=1 for exactly one cycle with current imem_waddr/imem_wdata.
  - Latency: write strobe occurs the cycle after the low byte is accepted.
  - Then increment waddr; if words written == latched count -> CHK, else -> HI.
- CHK: rx_ready=1. On transfer, compare byte against running checksum; mismatch sets err=1 -> FIN.
- FIN: done=1 for one cycle, busy=0 next cycle, cpu_hold=0 next cycle -> IDLE.
  - cpu_hold therefore spans from the cycle after start through the done cycle inclusive.
- ERR_DONE: done=1, err=1 for one cycle -> IDLE. cpu_hold stays 0.
- Sequencing limits:
  - start is ignored while busy.
  - No more than one byte is accepted per cycle.
  - There are no back-to-back imem writes; minimum 3 cycles per word.
- Stalls: rx_valid low in HI/LO/CHK holds state indefinitely; there is no timeout.
- Address: waddr never wraps, because count <= DEPTH. With count=DEPTH, the last write is to address DEPTH-1.
- Reset mid-load: immediate return to IDLE, cpu_hold=0. Words already written remain in memory; the partial word is discarded.
- Checksum error does not undo writes; software reloads on err.

Decomposition:
- Shared package holds:
  - constants INSTR_W=16, IMEM_ADDR_W=4, IMEM_DEPTH=16;
  - loader state enum (IDLE, HI, LO, WRITE, CHK, FIN, ERR_DONE).
- No sub-module needed. Byte packing, checksum and counters are kept in a single FSM module.
- Instruction memory gains a synchronous write port (we, waddr, wdata) at the top level; the read path is unchanged.

Test Plan:
- Load 2 words: count=2, bytes 0x20,0x58,0x2A,0x98, checksum 0x20^0x58^0x2A^0x98=0xCA, rx_valid always high. Required response:
  - writes mem[0]=0x2058, mem[1]=0x2A98;
  - done pulse, err=0;
  - cpu_hold high from the cycle after start through the done cycle.
- Bad checksum: same stream with checksum byte 0x00. Required response:
  - both words written;
  - done pulse with err=1, still set afterwards;
  - next valid start clears err.
- Invalid count: start with count=0 and, separately, count=17. Required response:
  - done and err within 2 cycles;
  - no imem_we, cpu_hold never asserts, rx_ready stays 0.
- Full depth with backpressure: count=16, rx_valid toggled randomly. Required response:
  - 16 writes to addresses 0..15 in order, exactly one per word;
  - no byte is lost or duplicated; done after the checksum byte.
- Reset mid-load: assert rst_n=0 after the high byte of word 3. Required response:
  - outputs return to reset values asynchronously;
  - mem[0..2] are retained and no write is made to address 3;
  - a subsequent full load succeeds.
- start asserted while busy: the second start is ignored, and the latched word_count remains unchanged.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry and FSM states.
package prog_loader_pkg;

    localparam int INSTR_W     = 16;
    localparam int IMEM_ADDR_W = 4;
    localparam int IMEM_DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        CHK,
        FIN,
        ERR_DONE
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Fills instruction memory from a byte stream: packs byte pairs into words, writes them
// sequentially from address 0, holds the CPU while loading and checks a trailing XOR byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_ADDR_ONE = ADDR_W'(1);

    loader_state_t     r_state;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_words;
    logic [7:0]        r_csum;

    logic              w_xfer;
    logic              w_count_ok;
    logic [ADDR_W:0]   w_words_inc;

    assign w_xfer      = rx_valid && r_ready;
    assign w_count_ok  = (word_count != '0) && (word_count <= LP_DEPTH);
    assign w_words_inc = r_words + LP_CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
            r_words <= '0;
            r_csum  <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_count_ok) begin
                            r_state <= HI;
                            r_count <= word_count;
                            r_words <= '0;
                            r_err   <= 1'b0;
                            r_csum  <= '0;
                            r_waddr <= '0;
                            r_hold  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ERR_DONE;
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (w_xfer) begin
                        r_wdata[DATA_W-1 -: 8] <= rx_data;
                        r_csum                 <= r_csum ^ rx_data;
                        r_state                <= LO;
                    end
                end
                LO: begin
                    if (w_xfer) begin
                        r_wdata[7:0] <= rx_data;
                        r_csum       <= r_csum ^ rx_data;
                        r_ready      <= 1'b0;
                        r_we         <= 1'b1;
                        r_state      <= WRITE;
                    end
                end
                WRITE: begin
                    // Address is held on the last word so it never steps past DEPTH-1.
                    r_words <= w_words_inc;
                    r_ready <= 1'b1;
                    if (w_words_inc == r_count) begin
                        r_state <= CHK;
                    end else begin
                        r_waddr <= r_waddr + LP_ADDR_ONE;
                        r_state <= HI;
                    end
                end
                CHK: begin
                    if (w_xfer) begin
                        if (rx_data != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_hold  <= 1'b0;
                    r_state <= IDLE;
                end
                ERR_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte-stream loads, checksum errors, bad counts,
// backpressure, mid-load reset and ignored restarts, checked against a memory model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  word_count;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mem [16];
    logic [15:0] exp_full [16];
    logic [3:0]  wr_addr [$];
    int          wr_cyc [$];
    logic [7:0]  stream [$];
    int          cyc;
    bit          prev_we;
    int          b2b;
    int          idx;
    bit          done_seen;
    int          done_cyc;
    logic        err_done;
    logic        err_at_start;
    int          hold_bad;
    bit          aborted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and record any memory write visible there.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (imem_we === 1'b1) begin
            mem[imem_waddr] = imem_wdata;
            wr_addr.push_back(imem_waddr);
            wr_cyc.push_back(cyc);
            if (prev_we) b2b++;
        end
        prev_we = (imem_we === 1'b1);
    endtask

    task automatic load(input logic [4:0] cnt, input bit rnd, input int abort_n, input int restart_at);
        int n;
        n = stream.size();
        idx = 0; done_seen = 0; done_cyc = 0; hold_bad = 0; aborted = 0;
        err_done = 1'b0; err_at_start = 1'b0;
        wr_addr.delete(); wr_cyc.delete(); b2b = 0;
        start = 1'b1; word_count = cnt; cyc = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            start = 1'b0;
            if (cyc == 1) begin
                err_at_start = err;
                word_count   = 5'd1;
            end
            if (cyc == restart_at) start = 1'b1;
            if (cpu_hold !== 1'b1 || busy !== 1'b1) hold_bad++;
            if (done === 1'b1) begin
                done_seen = 1; done_cyc = cyc; err_done = err;
                break;
            end
            if (abort_n > 0 && idx == abort_n) begin
                aborted = 1;
                break;
            end
            rx_valid = (idx < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            rx_data  = rx_valid ? stream[idx] : 8'($urandom);
            if (rx_valid && rx_ready === 1'b1) idx++;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic bad_start(input string tag, input logic [4:0] cnt);
        int rdy_seen;
        int hold_seen;
        rdy_seen = 0; hold_seen = 0; done_seen = 0; done_cyc = 0; err_done = 1'b0;
        wr_addr.delete();
        start = 1'b1; word_count = cnt; cyc = 0;
        rx_valid = 1'b1; rx_data = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            step();
            start = 1'b0;
            if (rx_ready === 1'b1) rdy_seen++;
            if (cpu_hold === 1'b1) hold_seen++;
            if (done === 1'b1 && !done_seen) begin
                done_seen = 1; done_cyc = cyc; err_done = err;
            end
        end
        rx_valid = 1'b0;
        check_eq({tag, "_done"},    32'(done_seen), 32'd1);
        check_eq({tag, "_latency"}, 32'(done_cyc <= 2 && done_cyc >= 1), 32'd1);
        check_eq({tag, "_err"},     32'(err_done), 32'd1);
        check_eq({tag, "_writes"},  32'(wr_addr.size()), 32'd0);
        check_eq({tag, "_ready"},   32'(rdy_seen), 32'd0);
        check_eq({tag, "_hold"},    32'(hold_seen), 32'd0);
    endtask

    task automatic idle_after(input string tag);
        step();
        check_eq({tag, "_idle"}, 32'({busy, cpu_hold, done}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] cs;
        int         order_bad;
        int         data_bad;

        rst_n = 1'b0; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
        cyc = 0; prev_we = 0; b2b = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;

        step(); step();
        check_eq("rst_ctrl",  32'({rx_ready, imem_we, cpu_hold, busy, done, err}), 32'd0);
        check_eq("rst_waddr", 32'(imem_waddr), 32'd0);
        check_eq("rst_wdata", 32'(imem_wdata), 32'd0);
        rst_n = 1'b1;
        step();

        // Two-word load with a correct checksum.
        stream = {8'h20, 8'h58, 8'h2A, 8'h98, 8'hCA};
        load(5'd2, 1'b0, 0, 0);
        check_eq("t1_done",     32'(done_seen), 32'd1);
        check_eq("t1_done_cyc", 32'(done_cyc), 32'd8);
        check_eq("t1_err",      32'(err_done), 32'd0);
        check_eq("t1_hold",     32'(hold_bad), 32'd0);
        check_eq("t1_nwr",      32'(wr_addr.size()), 32'd2);
        check_eq("t1_wr_lat",   32'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 32'd3);
        check_eq("t1_mem0",     32'(mem[0]), 32'h2058);
        check_eq("t1_mem1",     32'(mem[1]), 32'h2A98);
        check_eq("t1_bytes",    32'(idx), 32'd5);
        idle_after("t1");

        // Same stream with a wrong checksum byte.
        for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
        stream = {8'h20, 8'h58, 8'h2A, 8'h98, 8'h00};
        load(5'd2, 1'b0, 0, 0);
        check_eq("t2_done",  32'(done_seen), 32'd1);
        check_eq("t2_err",   32'(err_done), 32'd1);
        check_eq("t2_mem0",  32'(mem[0]), 32'h2058);
        check_eq("t2_mem1",  32'(mem[1]), 32'h2A98);
        step();
        step();
        check_eq("t2_sticky", 32'(err), 32'd1);

        // A valid start clears the sticky error.
        stream = {8'h12, 8'h34, 8'h26};
        load(5'd1, 1'b0, 0, 0);
        check_eq("t3_err_clr",  32'(err_at_start), 32'd0);
        check_eq("t3_err",      32'(err_done), 32'd0);
        check_eq("t3_done_cyc", 32'(done_cyc), 32'd5);
        check_eq("t3_mem0",     32'(mem[0]), 32'h1234);
        idle_after("t3");

        bad_start("cnt0", 5'd0);
        bad_start("cnt17", 5'd17);
        idle_after("t4");

        // Full depth with random rx_valid gaps.
        stream.delete();
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_full[i] = 16'($urandom);
            stream.push_back(exp_full[i][15:8]);
            stream.push_back(exp_full[i][7:0]);
            cs = cs ^ exp_full[i][15:8] ^ exp_full[i][7:0];
        end
        stream.push_back(cs);
        load(5'd16, 1'b1, 0, 0);
        order_bad = 0;
        data_bad  = 0;
        for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] != 4'(i)) order_bad++;
        for (int i = 0; i < 16; i++) if (mem[i] !== exp_full[i]) data_bad++;
        check_eq("t5_done",  32'(done_seen), 32'd1);
        check_eq("t5_err",   32'(err_done), 32'd0);
        check_eq("t5_nwr",   32'(wr_addr.size()), 32'd16);
        check_eq("t5_order", 32'(order_bad), 32'd0);
        check_eq("t5_data",  32'(data_bad), 32'd0);
        check_eq("t5_b2b",   32'(b2b), 32'd0);
        check_eq("t5_bytes", 32'(idx), 32'd33);
        idle_after("t5");

        // Reset right after the high byte of the fourth word.
        stream = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h77, 8'h88, 8'h00};
        load(5'd4, 1'b0, 7, 0);
        check_eq("t6_aborted", 32'(aborted), 32'd1);
        check_eq("t6_nwr",     32'(wr_addr.size()), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_ctrl",  32'({rx_ready, imem_we, cpu_hold, busy, done, err}), 32'd0);
        check_eq("t6_async_waddr", 32'(imem_waddr), 32'd0);
        check_eq("t6_async_wdata", 32'(imem_wdata), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("t6_mem0", 32'(mem[0]), 32'hA1B2);
        check_eq("t6_mem1", 32'(mem[1]), 32'hC3D4);
        check_eq("t6_mem2", 32'(mem[2]), 32'hE5F6);
        check_eq("t6_mem3", 32'(mem[3]), 32'(exp_full[3]));
        stream = {8'h20, 8'h58, 8'h2A, 8'h98, 8'hCA};
        load(5'd2, 1'b0, 0, 0);
        check_eq("t6_reload_done", 32'(done_seen), 32'd1);
        check_eq("t6_reload_err",  32'(err_done), 32'd0);
        check_eq("t6_reload_mem1", 32'(mem[1]), 32'h2A98);
        idle_after("t6");

        // Second start mid-load with a different count is ignored.
        load(5'd2, 1'b0, 0, 3);
        check_eq("t7_done_cyc", 32'(done_cyc), 32'd8);
        check_eq("t7_nwr",      32'(wr_addr.size()), 32'd2);
        check_eq("t7_err",      32'(err_done), 32'd0);
        idle_after("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
